// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Bundle of the control, LUT and status signals between the program-counter
//   sequencer and its environment (top level / testbench and branch LUT).
//
//   master modport : environment side (drives start/stall/decode/LUT data)
//   slave  modport : pc_sequencer side (drives LUT index, PC and status)
//
//   Signals:
//     start        start request
//     start_addr   PC loaded on an accepted start
//     stall        freeze PC and state (cycle counter keeps counting)
//     halt         decoded halt of the current instruction
//     branch_taken current instruction is a taken branch
//     target_idx   LUT index field of the current instruction
//     lut_idx      combinational copy of target_idx towards the LUT
//     lut_offset   signed branch offset returned by the LUT
//     pc           current program counter
//     running      sequencer is in RUN
//     done         sequencer is in DONE
//     fault        out-of-range branch target detected
//     cycle_count  saturating count of RUN cycles
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             stall;
    logic             halt;
    logic             branch_taken;
    logic [3:0]       target_idx;
    logic [3:0]       lut_idx;
    logic [PC_W-1:0]  lut_offset;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic             fault;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, start_addr, stall, halt, branch_taken, target_idx, lut_offset,
        input  lut_idx, pc, running, done, fault, cycle_count
    );

    modport slave (
        input  start, start_addr, stall, halt, branch_taken, target_idx, lut_offset,
        output lut_idx, pc, running, done, fault, cycle_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the 3BC processor. Owns the PC and advances
//   it by +1 or by a signed offset from the branch-target LUT. Implements the
//   start/done handshake, stall hold, halt and a saturating RUN-cycle counter.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-low reset
//     bus    pc_sequencer_if.slave (control inputs, LUT index/offset, status)
//
//   Optional feature (macro PC_BOUNDS_CHECK_EN):
//     When defined, a next PC that is negative or >= PROG_DEPTH is not taken;
//     the block raises fault and goes to DONE with the PC held. When
//     undefined, the PC simply wraps modulo 2^PC_W and fault stays 0.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_W       = 11,
    parameter int PROG_DEPTH = 1024,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    logic [PC_W-1:0]  pc_q, pc_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             fault_q, fault_next;

    logic [PC_W-1:0]  step_amt;
    logic [PC_W-1:0]  pc_sum;
    logic             out_of_range;

    // The LUT sits combinationally between index and offset; no pipeline stage.
    assign bus.lut_idx = bus.target_idx;

    assign step_amt = bus.branch_taken ? bus.lut_offset : PC_W'(1);
    // Plain PC_W-bit add: two's-complement offset wraps modulo 2^PC_W.
    assign pc_sum   = pc_q + step_amt;

`ifdef PC_BOUNDS_CHECK_EN
    logic signed [PC_W:0] pc_wide;

    // Zero-extended PC plus sign-extended step, in PC_W+1 signed bits.
    assign pc_wide      = $signed({1'b0, pc_q}) + $signed({step_amt[PC_W-1], step_amt});
    assign out_of_range = pc_wide[PC_W] ||
                          ({1'b0, pc_wide[PC_W-1:0]} >= (PC_W+1)'(PROG_DEPTH));
`else
    assign out_of_range = 1'b0;
`endif

    // Next-state / datapath decode.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        cnt_next   = cnt_q;
        fault_next = fault_q;

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    pc_next    = bus.start_addr;
                    cnt_next   = '0;
                    fault_next = 1'b0;
                end
            end

            RUN: begin
                // Counts every RUN edge, stalled ones included, and saturates.
                if (cnt_q != CNT_MAX) begin
                    cnt_next = cnt_q + CNT_W'(1);
                end

                if (bus.stall) begin
                    // Everything except the counter holds.
                end else if (bus.halt) begin
                    state_next = DONE;
                end else if (out_of_range) begin
                    fault_next = 1'b1;
                    state_next = DONE;
                end else begin
                    pc_next = pc_sum;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous) and all state uses <=.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            cnt_q   <= cnt_next;
            fault_q <= fault_next;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.running     = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.fault       = fault_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 3BC processor. It owns the PC and advances it by +1 or by a signed offset taken from the branch-target LUT. The decoder supplies the 4-bit LUT index, and this block forwards it to the LUT and consumes the 11-bit offset the LUT returns. It also implements the Start/Done handshake with the testbench/top level, stall hold, halt, and a run-cycle counter.

## Interface
- PC_W, 11, PC and LUT offset width; the offset is two's complement.
- PROG_DEPTH, 1024, number of valid instruction addresses (used only by the bounds check).
- CNT_W, 16, cycle counter width.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  start request; sampled in IDLE and DONE.
- StartAddr  in  PC_W  PC value loaded on accepted Start.
- Stall  in  1  freezes PC and state; CycleCount still counts.
- Halt  in  1  decoded halt for the current instruction.
- BranchTaken  in  1  current instruction is a taken branch.
- TargetIdx  in  4  LUT index field of the current instruction.
- LutIdx  out  4  combinational copy of TargetIdx, to LUT Index.
- LutOffset  in  PC_W  LUT Out (signed offset).
- PC  out  PC_W  current program counter (registered).
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- Fault  out  1  out-of-range target detected (macro only; otherwise tied 0).
- CycleCount  out  CNT_W  cycles spent in RUN, saturating.

## Operation
- States: IDLE, RUN, DONE. Running and Done are decoded from the state.
- Reset values, when Reset=0 at an edge: state=IDLE, PC=0, CycleCount=0, Fault=0. Reset overrides every other input, mid-run included.
- **IDLE:** Start=1 moves the block to RUN with PC=StartAddr and CycleCount=0. Otherwise it stays put.
- **RUN, priority order:**
  - Stall=1: PC holds, state holds, and Halt/BranchTaken are ignored.
  - Else Halt=1: move to DONE, PC holds, and BranchTaken is ignored.
  - Else BranchTaken=1: PC <= PC + LutOffset, modulo 2^PC_W.
  - Else: PC <= PC + 1, modulo 2^PC_W.
- Start during RUN is ignored.
- **DONE:** PC and CycleCount hold. Start=1 reloads PC=StartAddr, clears CycleCount and Fault, and moves to RUN.
- **CycleCount:** increments on every RUN-state edge, stalled cycles included. It saturates at 2^CNT_W−1 and does not wrap.
- **Offset arithmetic:** LutOffset is sign-extended, so 11'h68E (−370) subtracts 370.

## Timing
- Start to Running=1: 1 cycle. PC=StartAddr is visible in the same cycle Running rises.
- PC update latency: 1 cycle after a non-stalled RUN cycle.
- The LutIdx → LutOffset path is combinational within a cycle. There is no LUT pipeline stage.
- Halt to Done=1: 1 cycle. Done stays high until an accepted Start or a reset.
- Start asserted in the same cycle as Done rising is not seen until the next cycle, because Start is sampled only in DONE.
- A single-cycle Start pulse is sufficient; a held Start re-arms only from DONE.

## Configuration
- Macro: PC_BOUNDS_CHECK_EN.
- **Defined:**
  - The next PC is computed in PC_W+1 signed bits as zero-extended PC plus the offset, or plus 1.
  - If the result is negative or ≥ PROG_DEPTH, then instead of updating: Fault<=1, state<=DONE, PC holds.
  - Halt still has priority over the check.
- **Undefined:**
  - No check is made; the PC wraps modulo 2^PC_W.
  - Fault is constant 0.

## Test plan
- **Reset:** Reset=0 mid-RUN with PC=37 → next edge PC=0, Running=0, Done=0, CycleCount=0.
- **Start and sequential fetch:** Start with StartAddr=5, then 3 plain cycles → PC 5,6,7,8. Halt then → Done=1, PC=8, CycleCount=4.
- **Backward branch:** PC=400, BranchTaken=1, TargetIdx=0, LUT returns −370 → LutIdx=0, next PC=30.
- **Stall priority:** Stall=1 with Halt=1 and BranchTaken=1 at PC=12 for 2 cycles → PC=12 and Running=1 hold, CycleCount+2. Stall drops with Halt=1 → DONE.
- **Halt over branch, then restart:** Halt=1 with BranchTaken=1 → PC unchanged, DONE. Start with StartAddr=100 → RUN, PC=100, CycleCount=0.
- **Bounds check:**
  - With PC_BOUNDS_CHECK_EN: PC=10 plus offset −20 → Fault=1, Done=1, PC=10.
  - Without it: next PC = 2038 (11-bit wrap).
